// File: rtl/cpu_ctrl_pkg.sv
// Shared types and default constants for the CPU run controller and its instruction memory.
package cpu_ctrl_pkg;

    localparam int          IMEM_DEPTH     = 16;
    localparam int          IMEM_AW        = 4;
    localparam int          INSTR_DW       = 8;
    localparam logic [7:0]  HALT_INSTR_DEF = 8'hFF;
    localparam int unsigned MAX_CYCLES_DEF = 200;

    // Encoding is visible on state_o, so the values are fixed.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_STEP   = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

endpackage

// File: rtl/imem_16x8.sv
// Instruction memory: flop array with one synchronous write port and a combinational read port
// so the core can fetch in the same cycle it presents its PC.
module imem_16x8
    import cpu_ctrl_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = IMEM_AW,
    parameter int DW    = INSTR_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];

    // Storage: cleared by reset, written one byte per cycle during program load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // DEPTH equals 2**AW, so every raddr value is a valid entry (PC wraps naturally).
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/cpu_run_controller.sv
// Sequencer around the 8-bit core: loads the program memory, then holds the core in reset,
// free-runs it or single-steps it, and stops it on a halt instruction, a host request or
// an exhausted cycle budget.
//
//  state  | meaning
//  IDLE   | core in reset, waiting for load or run
//  LOAD   | accepting program bytes, address 0 upward
//  RUN    | core free-running until halt instr, halt_req or budget
//  STEP   | one enabled core cycle, then back to HALTED
//  HALTED | core out of reset but frozen, state preserved
module cpu_run_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int              DEPTH      = IMEM_DEPTH,
    parameter int              AW         = IMEM_AW,
    parameter int              DW         = INSTR_DW,
    parameter logic [DW-1:0]   HALT_INSTR = DW'(HALT_INSTR_DEF),
    parameter int unsigned     MAX_CYCLES = MAX_CYCLES_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_req,
    input  logic          load_valid,
    input  logic [DW-1:0] load_data,
    output logic          load_ready,
    input  logic          run_req,
    input  logic          step_req,
    input  logic          halt_req,
    input  logic          clear_req,
    input  logic [AW-1:0] cpu_addr,
    output logic [DW-1:0] cpu_instr,
    output logic          cpu_en,
    output logic          cpu_rst_n,
    output logic [2:0]    state_o,
    output logic          timeout,
    output logic [7:0]    cycle_cnt
);

    // Budget compare is done one bit wider than the counter so the saturated value still
    // compares as "reached" when a halted run is resumed past the budget.
    localparam logic [8:0]    BUDGET    = 9'(MAX_CYCLES);
    localparam bit            BUDGET_EN = (MAX_CYCLES != 0);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    logic [DW-1:0] mem_rdata;
    logic          mem_we;
    logic          is_halt_instr;
    logic          core_active;
    logic          budget_hit;
    logic [8:0]    cnt_inc;

    imem_16x8 #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_imem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .waddr (ptr_q),
        .wdata (load_data),
        .raddr (cpu_addr),
        .rdata (mem_rdata)
    );

    // Core sees no instructions while the memory is being rewritten.
    assign cpu_instr     = (state_q == ST_LOAD) ? '0 : mem_rdata;
    assign is_halt_instr = (cpu_instr == HALT_INSTR);

    // The halt instruction is never issued: the enable drops in the same cycle it is fetched.
    assign core_active = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !is_halt_instr;
    assign cpu_en      = core_active;
    assign cpu_rst_n   = (state_q == ST_RUN) || (state_q == ST_STEP) || (state_q == ST_HALTED);
    assign load_ready  = (state_q == ST_LOAD);
    assign mem_we      = (state_q == ST_LOAD) && load_valid;

    assign cnt_inc    = {1'b0, cnt_q} + 9'd1;
    assign budget_hit = BUDGET_EN && (state_q == ST_RUN) && core_active && (cnt_inc >= BUDGET);

    assign state_o   = state_q;
    assign timeout   = timeout_q;
    assign cycle_cnt = cnt_q;

    // Next-state, load pointer, cycle counter and timeout flag.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;

        if (core_active && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
        if (mem_we) begin
            ptr_d = ptr_q + 1'b1;
        end

        if (clear_req) begin
            state_d = ST_IDLE;
        end else begin
            if (budget_hit) begin
                timeout_d = 1'b1;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (run_req) begin
                        state_d   = ST_RUN;
                        cnt_d     = '0;
                        timeout_d = 1'b0;
                    end else if (load_req) begin
                        state_d = ST_LOAD;
                        ptr_d   = '0;
                    end
                end
                ST_LOAD: begin
                    if (mem_we && (ptr_q == LAST_ADDR)) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (halt_req || is_halt_instr || budget_hit) begin
                        state_d = ST_HALTED;
                    end
                end
                ST_STEP: begin
                    state_d = ST_HALTED;
                end
                ST_HALTED: begin
                    if (step_req) begin
                        state_d = ST_STEP;
                    end else if (run_req) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

endmodule
